// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file writeback arbiter.
// Holds the round-robin pointer encoding and the writeback request record.
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Bits are set on an accepted issue and cleared when the RF write lands.
module rf_scoreboard #(
    parameter int NUM_REGS   = rf_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_issue_valid,
    input  logic [ADDR_WIDTH-1:0] i_issue_rd,
    output logic                  o_issue_ready,
    input  logic                  i_clr_en,
    input  logic [ADDR_WIDTH-1:0] i_clr_rd,
    input  logic [ADDR_WIDTH-1:0] i_rs1,
    input  logic [ADDR_WIDTH-1:0] i_rs2,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic [NUM_REGS-1:0]   o_busy_list
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_issue_ready;
    logic                w_set;

    assign w_issue_ready = (i_issue_rd == '0) || !r_busy[i_issue_rd];
    assign w_set         = i_issue_valid && w_issue_ready && (i_issue_rd != '0);

    // Clear is applied after set so it wins on a same-register collision.
    always_comb begin
        w_busy_next = r_busy;
        if (w_set) begin
            w_busy_next[i_issue_rd] = 1'b1;
        end
        if (i_clr_en) begin
            w_busy_next[i_clr_rd] = 1'b0;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_issue_ready = w_issue_ready;
    assign o_rs1_busy    = (i_rs1 != '0) && r_busy[i_rs1];
    assign o_rs2_busy    = (i_rs2 != '0) && r_busy[i_rs2];
    assign o_busy_list   = r_busy;

    a_no_set_clr_collision: assert property (
        @(posedge i_clk) disable iff (i_rst)
        !(w_set && i_clr_en && (i_issue_rd == i_clr_rd))
    );

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin owner of the register file write port, shared by ALU and load
// writeback, with a per-register pending-write scoreboard for decode.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = rf_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid_in,
    input  logic [ADDR_WIDTH-1:0] alu_rd_in,
    input  logic [DATA_WIDTH-1:0] alu_data_in,
    output logic                  alu_ready_out,
    input  logic                  mem_valid_in,
    input  logic [ADDR_WIDTH-1:0] mem_rd_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_ready_out,
    input  logic                  issue_valid_in,
    input  logic [ADDR_WIDTH-1:0] issue_rd_in,
    output logic                  issue_ready_out,
    input  logic [ADDR_WIDTH-1:0] rs1_in,
    input  logic [ADDR_WIDTH-1:0] rs2_in,
    output logic                  rs1_busy_out,
    output logic                  rs2_busy_out,
    output logic [NUM_REGS-1:0]   busy_list_out,
    output logic                  rf_write_out,
    output logic [ADDR_WIDTH-1:0] rf_addr_c_out,
    output logic [DATA_WIDTH-1:0] rf_data_out
);

    import rf_pkg::*;

    prio_e                 r_prio;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    logic    w_alu_gnt;
    logic    w_mem_gnt;
    logic    w_gnt;
    wb_req_t w_alu_req;
    wb_req_t w_mem_req;
    wb_req_t w_sel_req;

    assign w_alu_req = '{rd: alu_rd_in, data: alu_data_in};
    assign w_mem_req = '{rd: mem_rd_in, data: mem_data_in};

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        w_alu_gnt = alu_valid_in && (!mem_valid_in || (r_prio == PRIO_ALU));
        w_mem_gnt = mem_valid_in && (!alu_valid_in || (r_prio == PRIO_MEM));
        w_gnt     = w_alu_gnt || w_mem_gnt;
        w_sel_req = w_alu_gnt ? w_alu_req : w_mem_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio  <= PRIO_ALU;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_wr_en <= w_gnt && (w_sel_req.rd != '0);
            if (w_gnt) begin
                r_addr <= w_sel_req.rd;
                r_data <= w_sel_req.data;
                r_prio <= w_alu_gnt ? PRIO_MEM : PRIO_ALU;
            end
        end
    end

    // The scoreboard clears from the registered write so busy drops exactly
    // when the register file captures the value.
    rf_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .i_clk         (clk),
        .i_rst         (reset),
        .i_issue_valid (issue_valid_in),
        .i_issue_rd    (issue_rd_in),
        .o_issue_ready (issue_ready_out),
        .i_clr_en      (r_wr_en),
        .i_clr_rd      (r_addr),
        .i_rs1         (rs1_in),
        .i_rs2         (rs2_in),
        .o_rs1_busy    (rs1_busy_out),
        .o_rs2_busy    (rs2_busy_out),
        .o_busy_list   (busy_list_out)
    );

    assign alu_ready_out = w_alu_gnt;
    assign mem_ready_out = w_mem_gnt;
    assign rf_write_out  = r_wr_en;
    assign rf_addr_c_out = r_addr;
    assign rf_data_out   = r_data;

    a_one_grant: assert property (
        @(posedge clk) disable iff (reset)
        !(w_alu_gnt && w_mem_gnt)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed table-driven bench for rf_wb_arbiter plus hand-written reset and
// contention sequences.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid_in;
    logic [4:0]  alu_rd_in;
    logic [31:0] alu_data_in;
    logic        alu_ready_out;
    logic        mem_valid_in;
    logic [4:0]  mem_rd_in;
    logic [31:0] mem_data_in;
    logic        mem_ready_out;
    logic        issue_valid_in;
    logic [4:0]  issue_rd_in;
    logic        issue_ready_out;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic        rs1_busy_out;
    logic        rs2_busy_out;
    logic [31:0] busy_list_out;
    logic        rf_write_out;
    logic [4:0]  rf_addr_c_out;
    logic [31:0] rf_data_out;

    int n_vec;
    int n_err;

    rf_wb_arbiter #(
        .DATA_WIDTH (32),
        .NUM_REGS   (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid_in    (alu_valid_in),
        .alu_rd_in       (alu_rd_in),
        .alu_data_in     (alu_data_in),
        .alu_ready_out   (alu_ready_out),
        .mem_valid_in    (mem_valid_in),
        .mem_rd_in       (mem_rd_in),
        .mem_data_in     (mem_data_in),
        .mem_ready_out   (mem_ready_out),
        .issue_valid_in  (issue_valid_in),
        .issue_rd_in     (issue_rd_in),
        .issue_ready_out (issue_ready_out),
        .rs1_in          (rs1_in),
        .rs2_in          (rs2_in),
        .rs1_busy_out    (rs1_busy_out),
        .rs2_busy_out    (rs2_busy_out),
        .busy_list_out   (busy_list_out),
        .rf_write_out    (rf_write_out),
        .rf_addr_c_out   (rf_addr_c_out),
        .rf_data_out     (rf_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a_v;
        logic [4:0]  a_rd;
        logic [31:0] a_d;
        logic        m_v;
        logic [4:0]  m_rd;
        logic [31:0] m_d;
        logic        i_v;
        logic [4:0]  i_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ar;
        logic        e_mr;
        logic        e_ir;
        logic        e_b1;
        logic        e_b2;
        logic        e_wr;
        logic        chk_ad;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid_in   = 1'b0;
        alu_rd_in      = 5'd0;
        alu_data_in    = 32'h0;
        mem_valid_in   = 1'b0;
        mem_rd_in      = 5'd0;
        mem_data_in    = 32'h0;
        issue_valid_in = 1'b0;
        issue_rd_in    = 5'd0;
        rs1_in         = 5'd0;
        rs2_in         = 5'd0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        // a_v a_rd a_d           m_v m_rd m_d          i_v i_rd  rs1   rs2    ar mr ir b1 b2 wr chk addr  data          busy
        tbl[0]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd0, 32'h0,        32'h0000_0000};
        tbl[1]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd10,5'd0, 5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd0, 32'h0,        32'h0000_0000};
        tbl[2]  = '{1'b1,5'd10,32'hffffffaa, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd10,5'd17, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,5'd0, 32'h0,        32'h0000_0400};
        tbl[3]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd10,5'd0,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,5'd10,32'hffffffaa, 32'h0000_0400};
        tbl[4]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd10,5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd10,32'hffffffaa, 32'h0000_0000};
        tbl[5]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd17,5'd0, 5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd10,32'hffffffaa, 32'h0000_0000};
        tbl[6]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd8, 5'd17,5'd10, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,5'd10,32'hffffffaa, 32'h0002_0000};
        tbl[7]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd17,5'd0, 5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd10,32'hffffffaa, 32'h0002_0100};
        tbl[8]  = '{1'b1,5'd17,32'hacf2255b, 1'b1,5'd8, 32'hcccccccc, 1'b1,5'd17,5'd0, 5'd0,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,5'd10,32'hffffffaa, 32'h0002_0100};
        tbl[9]  = '{1'b1,5'd17,32'hacf2255b, 1'b1,5'd8, 32'hcccccccc, 1'b1,5'd17,5'd0, 5'd0,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'd8, 32'hcccccccc, 32'h0002_0100};
        tbl[10] = '{1'b1,5'd17,32'hacf2255b, 1'b1,5'd8, 32'hcccccccc, 1'b1,5'd17,5'd0, 5'd0,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,5'd17,32'hacf2255b, 32'h0002_0000};
        tbl[11] = '{1'b1,5'd17,32'hacf2255b, 1'b0,5'd0, 32'h0,        1'b0,5'd17,5'd0, 5'd0,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,5'd8, 32'hcccccccc, 32'h0000_0000};
        tbl[12] = '{1'b1,5'd0, 32'hdeadbeef, 1'b0,5'd0, 32'h0,        1'b1,5'd0, 5'd0, 5'd0,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,5'd17,32'hacf2255b, 32'h0000_0000};
        tbl[13] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd17,5'd0, 5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,        32'h0000_0000};
        tbl[14] = '{1'b1,5'd5, 32'h00000055, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 5'd0,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,        32'h0002_0000};
        tbl[15] = '{1'b1,5'd6, 32'h00000066, 1'b1,5'd17,32'h12345678, 1'b0,5'd0, 5'd0, 5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,5'd5, 32'h00000055, 32'h0002_0000};
        tbl[16] = '{1'b1,5'd6, 32'h00000066, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd17,5'd5,  1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,5'd17,32'h12345678, 32'h0002_0000};
        tbl[17] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd17,5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,5'd6, 32'h00000066, 32'h0000_0000};

        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        chk("reset_wr",   -1, 32'(rf_write_out),  32'h0);
        chk("reset_busy", -1, busy_list_out,      32'h0);
        chk("reset_addr", -1, 32'(rf_addr_c_out), 32'h0);
        chk("reset_data", -1, rf_data_out,        32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            alu_valid_in   = tbl[i].a_v;
            alu_rd_in      = tbl[i].a_rd;
            alu_data_in    = tbl[i].a_d;
            mem_valid_in   = tbl[i].m_v;
            mem_rd_in      = tbl[i].m_rd;
            mem_data_in    = tbl[i].m_d;
            issue_valid_in = tbl[i].i_v;
            issue_rd_in    = tbl[i].i_rd;
            rs1_in         = tbl[i].rs1;
            rs2_in         = tbl[i].rs2;
            #1;
            n_vec++;
            chk("alu_ready",   i, 32'(alu_ready_out),   32'(tbl[i].e_ar));
            chk("mem_ready",   i, 32'(mem_ready_out),   32'(tbl[i].e_mr));
            chk("issue_ready", i, 32'(issue_ready_out), 32'(tbl[i].e_ir));
            chk("rs1_busy",    i, 32'(rs1_busy_out),    32'(tbl[i].e_b1));
            chk("rs2_busy",    i, 32'(rs2_busy_out),    32'(tbl[i].e_b2));
            chk("rf_write",    i, 32'(rf_write_out),    32'(tbl[i].e_wr));
            chk("busy_list",   i, busy_list_out,        tbl[i].e_busy);
            if (tbl[i].chk_ad) begin
                chk("rf_addr", i, 32'(rf_addr_c_out), 32'(tbl[i].e_addr));
                chk("rf_data", i, rf_data_out,        tbl[i].e_data);
            end
            @(negedge clk);
        end

        // Reset in the middle of a grant, with the pointer left at PRIO_MEM.
        drive_idle();
        issue_valid_in = 1'b1;
        issue_rd_in    = 5'd10;
        @(negedge clk);
        drive_idle();
        alu_valid_in = 1'b1;
        alu_rd_in    = 5'd10;
        alu_data_in  = 32'h0000_0001;
        #1;
        n_vec++;
        chk("rst_seq_grant", 100, 32'(alu_ready_out), 32'h1);
        @(negedge clk);
        alu_data_in = 32'h0000_0002;
        #1;
        n_vec++;
        chk("rst_seq_wr_pre",   101, 32'(rf_write_out), 32'h1);
        chk("rst_seq_busy_pre", 101, busy_list_out,     32'h0000_0400);
        reset = 1'b1;
        #1;
        n_vec++;
        chk("rst_seq_wr",   102, 32'(rf_write_out),  32'h0);
        chk("rst_seq_busy", 102, busy_list_out,      32'h0);
        chk("rst_seq_addr", 102, 32'(rf_addr_c_out), 32'h0);
        @(negedge clk);

        // Release with both requesters valid: grants must start at ALU and alternate.
        alu_valid_in = 1'b1;
        alu_rd_in    = 5'd17;
        alu_data_in  = 32'hacf2255b;
        mem_valid_in = 1'b1;
        mem_rd_in    = 5'd8;
        mem_data_in  = 32'hcccccccc;
        reset        = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            chk("cont_alu_ready", 200 + k, 32'(alu_ready_out), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("cont_mem_ready", 200 + k, 32'(mem_ready_out), (k % 2 == 0) ? 32'h0 : 32'h1);
            if (k > 0) begin
                chk("cont_wr",   200 + k, 32'(rf_write_out),  32'h1);
                chk("cont_addr", 200 + k, 32'(rf_addr_c_out), (k % 2 == 1) ? 32'd17 : 32'd8);
                chk("cont_data", 200 + k, rf_data_out,        (k % 2 == 1) ? 32'hacf2255b : 32'hcccccccc);
            end
            @(negedge clk);
        end

        drive_idle();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
